// File: rtl/alu_pkg.sv
// Shared types and default sizing for the ALU core and its multiplier.
package alu_pkg;

  localparam int ALU_WIDTH   = 8;
  localparam int ALU_MUL_LAT = 3;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_AND  = 3'd2,
    OP_XOR  = 3'd3,
    OP_MUL  = 3'd4,
    OP_RSV5 = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RST  = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul.sv
// Pipelined unsigned multiplier. Its LAT-1 registers plus the caller's result
// register make up the LAT-cycle multiply path.
module alu_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int LAT   = ALU_MUL_LAT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_valid,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int STAGES = LAT - 1;

  logic [2*WIDTH-1:0] r_prod [STAGES];
  logic [STAGES-1:0]  r_vld;
  logic [2*WIDTH-1:0] w_a;
  logic [2*WIDTH-1:0] w_b;

  assign w_a = {{WIDTH{1'b0}}, i_a};
  assign w_b = {{WIDTH{1'b0}}, i_b};

  // Operands are only captured on a launch, so later input changes cannot leak in.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
      for (int i = 0; i < STAGES; i++) r_prod[i] <= '0;
    end else begin
      r_vld[0] <= i_valid;
      if (i_valid) r_prod[0] <= w_a * w_b;
      for (int i = 1; i < STAGES; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_prod[i] <= r_prod[i-1];
      end
    end
  end

  assign o_valid   = r_vld[STAGES-1];
  assign o_product = r_prod[STAGES-1];

endmodule

// File: rtl/alu_core.sv
// Small ALU: single-cycle logic/add ops, pipelined multiply, one-cycle done pulse.
// The port named rst_n is an active-high asynchronous reset.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int MUL_LAT = ALU_MUL_LAT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               start,
  input  logic [2:0]         opcode,
  output logic [2*WIDTH-1:0] result,
  output logic               done
);

  state_t             r_state;
  opcode_t            w_op;
  logic               w_launch;
  logic               w_mulLaunch;
  logic               w_mulValid;
  logic [2*WIDTH-1:0] w_product;
  logic [2*WIDTH-1:0] w_a;
  logic [2*WIDTH-1:0] w_b;
  logic [2*WIDTH-1:0] w_logicResult;

  assign w_op        = opcode_t'(opcode);
  assign w_launch    = (r_state == IDLE) && start;
  assign w_mulLaunch = w_launch && (w_op == OP_MUL);
  assign w_a         = {{WIDTH{1'b0}}, A};
  assign w_b         = {{WIDTH{1'b0}}, B};

  alu_mul #(
    .WIDTH (WIDTH),
    .LAT   (MUL_LAT)
  ) u_mul (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_valid   (w_mulLaunch),
    .i_a       (A),
    .i_b       (B),
    .o_valid   (w_mulValid),
    .o_product (w_product)
  );

  always_comb begin
    w_logicResult = '0;
    case (w_op)
      OP_ADD:  w_logicResult = w_a + w_b;
      OP_AND:  w_logicResult = w_a & w_b;
      OP_XOR:  w_logicResult = w_a ^ w_b;
      default: w_logicResult = '0;
    endcase
  end

  // done defaults low so it can only be high for the single DONE cycle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= IDLE;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_mulLaunch) begin
            r_state <= BUSY;
          end else if (w_launch) begin
            r_state <= DONE;
            result  <= w_logicResult;
            done    <= 1'b1;
          end
        end
        BUSY: begin
          if (w_mulValid) begin
            r_state <= DONE;
            result  <= w_product;
            done    <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core: stimulus pushes expectations into a
// scoreboard queue, a monitor pops and compares on every done pulse.
module tb_alu_core;

  localparam int WIDTH = 8;
  localparam int LAT   = 3;

  typedef struct {
    logic [15:0] res;
    int          cyc;
    string       name;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic              start;
  logic [2:0]        opcode;
  logic [15:0]       result;
  logic              done;

  int   checks;
  int   errors;
  int   cycleCount;
  exp_t sbQ[$];

  alu_core #(.WIDTH(WIDTH), .MUL_LAT(LAT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .start  (start),
    .opcode (opcode),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Pops one expectation per done pulse; a pulse with nothing queued is an error.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone: got done=1 at cycle %0d expected no pulse", cycleCount);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput({e.name, "_result"}, 32'(result), 32'(e.res));
        checkOutput({e.name, "_cycle"}, 32'(cycleCount), 32'(e.cyc));
      end
    end
  end

  // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
  task automatic applyStimulus(input string name, input logic [2:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic [15:0] expRes, input int lat);
    exp_t e;
    bit   seen;
    e.res  = expRes;
    e.cyc  = cycleCount + lat;
    e.name = name;
    sbQ.push_back(e);
    A      = a;
    B      = b;
    opcode = op;
    start  = 1'b1;
    @(negedge clk);
    A = 8'($urandom);
    B = 8'($urandom);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got no done expected done within 20 cycles", name);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cycleCount = 0;
    rst_n  = 1'b1;
    start  = 1'b0;
    A      = '0;
    B      = '0;
    opcode = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetResult", 32'(result), 32'h0);
    checkOutput("resetDone", 32'(done), 32'h0);
    rst_n = 1'b0;

    // First edge after reset release samples this request.
    applyStimulus("addCarry", 3'd1, 8'hFF, 8'h01, 16'h0100, 1);
    applyStimulus("and",      3'd2, 8'hF0, 8'h3C, 16'h0030, 1);
    applyStimulus("xor",      3'd3, 8'hAA, 8'hFF, 16'h0055, 1);
    applyStimulus("addMid",   3'd1, 8'h7F, 8'h01, 16'h0080, 1);
    applyStimulus("mulMax",   3'd4, 8'hFF, 8'hFF, 16'hFE01, LAT);
    applyStimulus("mulSmall", 3'd4, 8'h0C, 8'h0B, 16'h0084, LAT);
    applyStimulus("mulZero",  3'd4, 8'h00, 8'hFF, 16'h0000, LAT);
    applyStimulus("mul16",    3'd4, 8'h10, 8'h10, 16'h0100, LAT);
    applyStimulus("nop",      3'd0, 8'h12, 8'h34, 16'h0000, 1);
    applyStimulus("add128",   3'd1, 8'h80, 8'h80, 16'h0100, 1);
    applyStimulus("rsv5",     3'd5, 8'h55, 8'h66, 16'h0000, 1);
    applyStimulus("mulSet",   3'd4, 8'h03, 8'h05, 16'h000F, LAT);
    applyStimulus("rsv6",     3'd6, 8'h01, 8'h01, 16'h0000, 1);
    applyStimulus("mulSet2",  3'd4, 8'h02, 8'h09, 16'h0012, LAT);
    applyStimulus("rstOp",    3'd7, 8'hFF, 8'hFF, 16'h0000, 1);

    // start held across done: the next IDLE edge launches with the new A.
    begin
      exp_t e1, e2;
      bit   ok;
      e1.res = 16'h0003; e1.cyc = cycleCount + 1; e1.name = "holdFirst";
      e2.res = 16'h0006; e2.cyc = cycleCount + 3; e2.name = "holdSecond";
      sbQ.push_back(e1);
      sbQ.push_back(e2);
      A = 8'h01; B = 8'h02; opcode = 3'd3; start = 1'b1;
      @(negedge clk);
      A = 8'h04;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (done === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("[TB] FAIL holdStart_timeout: got no second done expected one within 10 cycles");
      end
      start = 1'b0;
      @(negedge clk);
    end

    // Reset asserted mid-multiply: no done pulse, result cleared at once.
    A = 8'hFF; B = 8'hFF; opcode = 3'd4; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midMulRstResult", 32'(result), 32'h0);
    checkOutput("midMulRstDone", 32'(done), 32'h0);
    start = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    checkOutput("afterRstResult", 32'(result), 32'h0);
    rst_n = 1'b0;
    applyStimulus("addAfterRst", 3'd1, 8'h03, 8'h04, 16'h0007, 1);

    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 100us");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
